aes_inv_key_schedule: RTL and testbench
=======================================

Name: aes_inv_key_schedule

Overview:
- Iterative AES-128 round-key generator for the decryption datapath. It delivers round keys in reverse order: round 10 first, round 0 last.
- Accepts the 128-bit cipher key and runs the forward schedule for 10 cycles to reach round key 10.
- Then walks the schedule backwards, one round key per handshake.
- Sits between the key register file and the inverse-cipher round engine. It is the mirror of the forward per-round expansion step.

Parameters:
- NUM_ROUNDS, 10, number of AES rounds; only 10 (AES-128) is supported, and elaboration fails otherwise.
- KEY_W, 128, round-key width; fixed, present for readability.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key_valid  input  1  cipher key offered.
- key_ready  output  1  high only in IDLE; key is accepted when key_valid and key_ready are both high.
- key_in  input  128  cipher key, bit order [0:127], byte 0 = bits [0:7].
- abort  input  1  synchronous flush back to IDLE.
- rk_valid  output  1  rk_data holds a valid round key.
- rk_ready  input  1  consumer accepts the key.
- rk_data  output  128  current round key, [0:127] ordering.
- rk_round  output  4  round index of rk_data (10 down to 0).
- busy  output  1  high in EXPAND or SERVE.

Behaviour:
- Reset values: key_ready=0, rk_valid=0, busy=0, rk_data=0, rk_round=0. State is IDLE. key_ready rises the cycle after reset deasserts.
- States: IDLE, EXPAND, SERVE.
- IDLE:
  - key_ready=1.
  - On accept, register key_in into rk_data, set cnt=1, go to EXPAND.
- EXPAND: each cycle, apply the forward step with Rcon(cnt):
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon
  - w1' = w0' ^ w1
  - w2' = w1' ^ w2
  - w3' = w2' ^ w3
  - cnt increments. When cnt==10 is applied, go to SERVE with rk_round=10 and rk_valid=1.
  - Latency: key accept edge to rk_valid high is exactly 11 cycles.
- SERVE:
  - rk_valid=1 and rk_data is stable while rk_ready=0.
  - On handshake with rk_round=r>0, register the inverse step with Rcon(r):
    - w3 = w3' ^ w2'
    - w2 = w2' ^ w1'
    - w1 = w1' ^ w0'
    - w0 = w0' ^ SubWord(RotWord(w3)) ^ Rcon(r)
    - Then rk_round=r-1.
  - Back-to-back handshakes give one key per cycle.
  - On handshake with rk_round=0, go to IDLE: rk_valid=0 next cycle, rk_data holds the cipher key.
- Rcon(1..10) = 01,02,04,08,10,20,40,80,1b,36, placed in byte 0 (bits [0:7]); the other bytes are 0.
- key_valid while not IDLE is ignored (key_ready=0). There is no queuing.
- abort has priority over all transitions:
  - Next cycle: IDLE, rk_valid=0, rk_round=0.
  - rk_data is held, not cleared.
  - Simultaneous abort with an rk handshake: the handshake completes (the consumer saw the data), but no next key is computed.
- Reset mid-operation: immediate return to reset values; no partial state survives.
- One SubWord instance (4 S-boxes) is shared. Its input is muxed between the current w3 (EXPAND) and w3'^w2' (SERVE).

Optional Feature:
- Macro: AES_INVKEY_DIRECT_LOAD_EN.
- Defined:
  - Adds input key_is_last (1 bit), sampled at key accept.
  - If 1, key_in is taken as round key 10: skip EXPAND and enter SERVE the next cycle with rk_round=10 (latency 1).
  - If 0, normal expansion.
- Undefined: the port is absent and every key is expanded.

Decomposition:
- Package aes_pkg:
  - constants AES_NR=10 and AES_KEY_W=128;
  - Rcon lookup function;
  - state enum type (IDLE/EXPAND/SERVE);
  - shared S-box function, also used by the forward key expansion and SubBytes.
- Sub-module aes_sub_word: 32-bit RotWord+SubWord combinational unit, instantiated once.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready tied high -> rk_valid 11 cycles after accept:
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - next cycle, round 9 = ac7766f319fadc2128d12941575c006e;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 0 = cipher key;
  - then IDLE with key_ready=1.
- rk_ready toggled randomly, same key -> rk_data/rk_round stable during stalls; sequence identical to the previous scenario; exactly 11 handshakes.
- abort asserted at rk_round=6 -> rk_valid=0 next cycle; new key 000102030405060708090a0b0c0d0e0f then yields round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- rst_n pulsed low during EXPAND (cnt=5) -> all outputs 0 immediately; after release, a fresh key expands correctly.
- key_valid held high during SERVE -> key_ready=0, key not consumed; accepted only after round 0 completes.
- With AES_INVKEY_DIRECT_LOAD_EN, key_is_last=1, key_in=d014f9a8…0ca6 -> rk_valid one cycle later with rk_round=10; round 0 = 2b7e1516…4f3c.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, round constants, key-schedule FSM states
// and the forward S-box. The S-box is also used by the forward key
// expansion and by SubBytes.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    // Key-schedule controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_SERVE  = 2'd2
    } aes_ks_state_e;

    // Forward S-box, byte 0x00 first. Index 0 of the vector is the MSB of
    // entry 0x00, so entry b lives at bits [8*b : 8*b+7].
    localparam logic [0:2047] AES_SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Forward S-box lookup.
    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return AES_SBOX_TABLE[{b, 3'b000} +: 8];
    endfunction

    // Round constant for rounds 1..10; zero for any other index.
    function automatic logic [7:0] aes_rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// RotWord followed by SubWord on one 32-bit key word (byte 0 in bits
// [31:24]). Purely combinational: four S-box lookups.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    logic [31:0] rot_word;

    // Rotate one byte left: byte 0 moves to the last position.
    assign rot_word = {word_i[23:0], word_i[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign word_o[gi*8 +: 8] = aes_sbox(rot_word[gi*8 +: 8]);
        end
    endgenerate

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 round-key generator for decryption. Expands the cipher
// key forward to round key 10, then steps the schedule backwards one round
// key per rk handshake, ending with the cipher key itself (round 0).
// Optional build macro: AES_INVKEY_DIRECT_LOAD_EN adds key_is_last, which
// lets the caller load round key 10 directly and skip the expansion.
module aes_inv_key_schedule
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR,
    parameter int KEY_W      = AES_KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [0:KEY_W-1] key_in,
`ifdef AES_INVKEY_DIRECT_LOAD_EN
    input  logic             key_is_last,
`endif
    input  logic             abort,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [0:KEY_W-1] rk_data,
    output logic [3:0]       rk_round,
    output logic             busy
);

    // Only the AES-128 schedule is implemented.
    generate
        if (NUM_ROUNDS != 10 || KEY_W != 128) begin : g_bad_config
            $error("aes_inv_key_schedule supports only NUM_ROUNDS=10, KEY_W=128");
        end
    endgenerate

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    aes_ks_state_e    state_q, state_d;
    logic [KEY_W-1:0] data_q, data_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       round_q, round_d;
    logic             valid_q, valid_d;
    logic             kready_q, kready_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] sw_in, sw_out, rcon_w;
    logic [3:0]  rcon_idx;
    logic [KEY_W-1:0] fwd_key, inv_key;
    logic [31:0] inv_w3;
    logic        key_accept;
    logic        rk_fire;

    // Word 0 holds byte 0 in its most significant byte.
    assign w0 = data_q[127:96];
    assign w1 = data_q[95:64];
    assign w2 = data_q[63:32];
    assign w3 = data_q[31:0];

    // Going backwards, the word fed to SubWord is the recovered previous w3,
    // which is w3' ^ w2' of the current round key.
    assign inv_w3   = w3 ^ w2;
    assign sw_in    = (state_q == ST_SERVE) ? inv_w3 : w3;
    assign rcon_idx = (state_q == ST_SERVE) ? round_q : cnt_q;
    assign rcon_w   = {aes_rcon(rcon_idx), 24'h000000};

    // The single shared RotWord/SubWord unit.
    aes_sub_word u_sub_word (
        .word_i (sw_in),
        .word_o (sw_out)
    );

    // Forward and inverse round steps built around the shared SubWord result.
    always_comb begin
        logic [31:0] f0, f1, f2, f3;
        f0      = w0 ^ sw_out ^ rcon_w;
        f1      = f0 ^ w1;
        f2      = f1 ^ w2;
        f3      = f2 ^ w3;
        fwd_key = {f0, f1, f2, f3};
        inv_key = {w0 ^ sw_out ^ rcon_w, w1 ^ w0, w2 ^ w1, inv_w3};
    end

    assign key_accept = key_valid && kready_q;
    assign rk_fire    = valid_q && rk_ready;

    // Next-state logic; abort overrides every transition and freezes data.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE: begin
                if (key_accept) begin
                    data_d = key_in;
`ifdef AES_INVKEY_DIRECT_LOAD_EN
                    if (key_is_last) begin
                        state_d = ST_SERVE;
                        round_d = LAST_ROUND;
                    end else begin
                        state_d = ST_EXPAND;
                        cnt_d   = 4'd1;
                    end
`else
                    state_d = ST_EXPAND;
                    cnt_d   = 4'd1;
`endif
                end
            end
            ST_EXPAND: begin
                data_d = fwd_key;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == LAST_ROUND) begin
                    state_d = ST_SERVE;
                    round_d = LAST_ROUND;
                end
            end
            ST_SERVE: begin
                if (rk_fire) begin
                    if (round_q == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        data_d  = inv_key;
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                round_d = 4'd0;
            end
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            data_d  = data_q;
            round_d = 4'd0;
        end
    end

    // Handshake flags follow the next state so they line up with it.
    always_comb begin
        valid_d  = (state_d == ST_SERVE);
        kready_d = (state_d == ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            cnt_q    <= 4'd0;
            round_q  <= 4'd0;
            valid_q  <= 1'b0;
            kready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            round_q  <= round_d;
            valid_q  <= valid_d;
            kready_q <= kready_d;
        end
    end

    assign key_ready = kready_q;
    assign rk_valid  = valid_q;
    assign rk_data   = data_q;
    assign rk_round  = round_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule. The reference model builds
// the S-box from GF(2^8) inversion and runs the textbook 44-word forward
// expansion; DUT round keys are compared against that table.
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic         abort = 1'b0;
    logic         rk_valid;
    logic         rk_ready = 1'b0;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         busy;
`ifdef AES_INVKEY_DIRECT_LOAD_EN
    logic         key_is_last = 1'b0;
`endif

    always #5 clk = ~clk;

    aes_inv_key_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
`ifdef AES_INVKEY_DIRECT_LOAD_EN
        .key_is_last (key_is_last),
`endif
        .abort     (abort),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_data   (rk_data),
        .rk_round  (rk_round),
        .busy      (busy)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;

    logic [7:0]   sbox_m [256];
    logic [7:0]   rcon_m [11];
    logic [127:0] exp_rk [11];
    logic [127:0] obs_rk [11];
    int           hs_cnt;
    int           serve_cyc;

    typedef struct {
        logic [127:0] key;
        logic [127:0] r10;
        logic [127:0] r9;
        logic         has_r9;
        logic [127:0] r1;
        int           ready_pct;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    // S-box = affine transform of the multiplicative inverse.
    task automatic build_tables();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
        rcon_m[0] = 8'h00;
        rcon_m[1] = 8'h01;
        for (int i = 2; i < 11; i++) rcon_m[i] = xtime(rcon_m[i-1]);
    endtask

    // Standard word-array key expansion; exp_rk[r] is round key r.
    task automatic expand_model(input logic [127:0] key);
        logic [31:0] w [44];
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rcon_m[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called at a negedge; the following posedge accepts the key.
    task automatic accept_key(input logic [127:0] k);
        int n = 0;
        while (!key_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!key_ready) chk("key_ready_timeout", 128'(key_ready), 128'd1);
        key_in    = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Edges counted include the accept edge itself.
    task automatic wait_rk_valid(input int exp_edges);
        int lat = 0;
        while (!rk_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 128'(lat + 1), 128'(exp_edges));
        chk("first_round", 128'(rk_round), 128'd10);
    endtask

    // Drains all round keys with rk_ready high pct% of cycles.
    task automatic serve_all(input int pct);
        logic         stalled = 1'b0;
        logic [127:0] prev_d = '0;
        logic [3:0]   prev_r = '0;
        logic         done = 1'b0;
        hs_cnt    = 0;
        serve_cyc = 0;
        while (!done && serve_cyc < 2000) begin
            if (stalled) begin
                chk("stall_data", rk_data, prev_d);
                chk("stall_round", 128'(rk_round), 128'(prev_r));
            end
            rk_ready = ($urandom_range(0, 99) < pct);
            if (rk_valid && rk_ready) begin
                int r = 10 - hs_cnt;
                chk("rk_round", 128'(rk_round), 128'(r));
                chk("rk_data", rk_data, exp_rk[r]);
                obs_rk[r] = rk_data;
                hs_cnt++;
                if (r == 0) done = 1'b1;
                stalled = 1'b0;
            end else begin
                stalled = rk_valid;
                prev_d  = rk_data;
                prev_r  = rk_round;
            end
            @(negedge clk);
            serve_cyc++;
        end
        rk_ready = 1'b0;
        chk("handshakes", 128'(hs_cnt), 128'd11);
        if (pct >= 100) chk("b2b_cycles", 128'(serve_cyc), 128'd11);
    endtask

    task automatic check_idle_after(input logic [127:0] cipher_key);
        chk("idle_rk_valid", 128'(rk_valid), 128'd0);
        chk("idle_key_ready", 128'(key_ready), 128'd1);
        chk("idle_busy", 128'(busy), 128'd0);
        chk("idle_rk_data", rk_data, cipher_key);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_key_ready"}, 128'(key_ready), 128'd0);
        chk({tag, "_rk_valid"}, 128'(rk_valid), 128'd0);
        chk({tag, "_busy"}, 128'(busy), 128'd0);
        chk({tag, "_rk_data"}, rk_data, 128'd0);
        chk({tag, "_rk_round"}, 128'(rk_round), 128'd0);
    endtask

    task automatic full_run(input logic [127:0] k, input int pct);
        expand_model(k);
        accept_key(k);
        wait_rk_valid(11);
        serve_all(pct);
        check_idle_after(k);
    endtask

    initial begin
        logic [127:0] k1, k2;

        vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    r10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                    r9:  128'hac7766f319fadc2128d12941575c006e, has_r9: 1'b1,
                    r1:  128'ha0fafe1788542cb123a339392a6c7605, ready_pct: 100};
        vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    r10: 128'h13111d7fe3944a17f307a78b4d2b30c5,
                    r9:  128'h549932d1f08557681093ed9cbe2c974e, has_r9: 1'b1,
                    r1:  128'hd6aa74fdd2af72fadaa678f1d6ab76fe, ready_pct: 60};
        vecs[2] = '{key: 128'h0,
                    r10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e,
                    r9:  128'h0, has_r9: 1'b0,
                    r1:  128'h62636363626363636263636362636363, ready_pct: 40};

        build_tables();

        // Reset values, then key_ready rising one cycle after release.
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        chk("ready_before_edge", 128'(key_ready), 128'd0);
        @(negedge clk);
        chk("ready_after_release", 128'(key_ready), 128'd1);

        // Known-answer vectors.
        for (int i = 0; i < 3; i++) begin
            full_run(vecs[i].key, vecs[i].ready_pct);
            chk($sformatf("vec%0d_r10", i), obs_rk[10], vecs[i].r10);
            if (vecs[i].has_r9) chk($sformatf("vec%0d_r9", i), obs_rk[9], vecs[i].r9);
            chk($sformatf("vec%0d_r1", i), obs_rk[1], vecs[i].r1);
            chk($sformatf("vec%0d_r0", i), obs_rk[0], vecs[i].key);
        end

        // Same FIPS key with random stalls.
        full_run(vecs[0].key, 35);

        // Abort at round 6, together with a handshake.
        expand_model(vecs[0].key);
        accept_key(vecs[0].key);
        wait_rk_valid(11);
        rk_ready = 1'b1;
        for (int c = 0; c < 20 && !(rk_valid && rk_round == 4'd6); c++) @(negedge clk);
        chk("abort_at_r6", rk_data, exp_rk[6]);
        abort = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        rk_ready = 1'b0;
        chk("abort_rk_valid", 128'(rk_valid), 128'd0);
        chk("abort_rk_round", 128'(rk_round), 128'd0);
        chk("abort_rk_data_held", rk_data, exp_rk[6]);
        chk("abort_key_ready", 128'(key_ready), 128'd1);
        full_run(vecs[1].key, 100);
        chk("after_abort_r10", obs_rk[10], vecs[1].r10);

        // Asynchronous reset mid-expansion (cnt=5).
        k1 = rand128();
        accept_key(k1);
        repeat (4) @(negedge clk);
        chk("expand_busy", 128'(busy), 128'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_ready", 128'(key_ready), 128'd1);
        full_run(rand128(), 70);

        // key_valid held through SERVE: accepted only after round 0.
        k1 = rand128();
        k2 = rand128();
        expand_model(k1);
        accept_key(k1);
        wait_rk_valid(11);
        key_in    = k2;
        key_valid = 1'b1;
        chk("serve_key_ready", 128'(key_ready), 128'd0);
        serve_all(60);
        check_idle_after(k1);
        @(negedge clk);
        key_valid = 1'b0;
        chk("held_key_accepted", 128'(busy), 128'd1);
        expand_model(k2);
        wait_rk_valid(11);
        serve_all(100);
        check_idle_after(k2);

        // Random keys, random back-pressure.
        for (int i = 0; i < 3; i++) full_run(rand128(), $urandom_range(25, 95));

`ifdef AES_INVKEY_DIRECT_LOAD_EN
        // Direct load of round key 10.
        expand_model(vecs[0].key);
        key_is_last = 1'b1;
        accept_key(vecs[0].r10);
        key_is_last = 1'b0;
        wait_rk_valid(1);
        serve_all(100);
        check_idle_after(vecs[0].key);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
